// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the end-around-carry ripple adder.
package ripple_carry_adder_pkg;

  localparam int unsigned RCA_W_DEFAULT = 4;

endpackage

// File: rtl/rca_full_adder.sv
// Single-bit full-adder cell used to build the ripple chain.
module rca_full_adder (
  input  logic in0,
  input  logic in1,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = in0 ^ in1 ^ cin;
  assign cout = (in0 & in1) | (in0 & cin) | (in1 & cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// W-bit ripple-carry adder with end-around carry, plus a one-cycle registered copy.
// Optional sticky carry flag enabled by defining RCA_STICKY_CARRY_EN.
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int unsigned W = RCA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [W-1:0] sum_q,
  output logic         cout_q
`ifdef RCA_STICKY_CARRY_EN
  ,
  output logic         carry_sticky
`endif
);

  logic [W:0]   carry;
  logic [W-1:0] raw;
  logic [W-1:0] inc_c;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_pass1
    rca_full_adder u_fa (
      .in0  (in0[i]),
      .in1  (in1[i]),
      .cin  (carry[i]),
      .sum  (raw[i]),
      .cout (carry[i+1])
    );
  end

  // Second pass folds the wrap carry back in; it cannot carry out, so the top carry is dropped.
  always_comb begin
    inc_c    = '0;
    inc_c[0] = carry[W];
    for (int i = 0; i < W - 1; i++) begin
      inc_c[i+1] = raw[i] & inc_c[i];
    end
  end

  assign sum  = raw ^ inc_c;
  assign cout = carry[W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

`ifdef RCA_STICKY_CARRY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (cout) begin
      sticky_q <= 1'b1;
    end
  end

  assign carry_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder: W=4 directed/exhaustive, W=8 random, optional sticky flag.
module tb_ripple_carry_adder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in0 = '0, in1 = '0, sum, sum_q;
  logic       cout, cout_q;
  logic [7:0] a8 = '0, b8 = '0, s8, s8_q;
  logic       c8, c8_q;
`ifdef RCA_STICKY_CARRY_EN
  logic       carry_sticky, sticky8;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  ripple_carry_adder #(.W(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in0     (in0),
    .in1     (in1),
    .sum     (sum),
    .cout    (cout),
    .sum_q   (sum_q),
    .cout_q  (cout_q)
`ifdef RCA_STICKY_CARRY_EN
    ,
    .carry_sticky (carry_sticky)
`endif
  );

  ripple_carry_adder #(.W(8)) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .in0     (a8),
    .in1     (b8),
    .sum     (s8),
    .cout    (c8),
    .sum_q   (s8_q),
    .cout_q  (c8_q)
`ifdef RCA_STICKY_CARRY_EN
    ,
    .carry_sticky (sticky8)
`endif
  );

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    logic [3:0] s;
    t = {1'b0, a} + {1'b0, b};
    s = t[3:0] + {3'b0, t[4]};
    return {t[4], s};
  endfunction

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] s;
    t = {1'b0, a} + {1'b0, b};
    s = t[7:0] + {7'b0, t[8]};
    return {t[8], s};
  endfunction

  // Drive on the falling edge, check combinational outputs 1 unit later, queue the registered result.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic rst_n,
                       input logic [3:0] exp_s, input logic exp_c, input string name);
    @(negedge clk);
    in0     = a;
    in1     = b;
    reset_n = rst_n;
    exp_q.push_back(rst_n ? {exp_c, exp_s} : 5'b0);
    name_q.push_back({name, "_q"});
    #1;
    check({name, "_sum"}, {5'b0, sum}, {5'b0, exp_s});
    check({name, "_cout"}, {8'b0, cout}, {8'b0, exp_c});
  endtask

  // Monitor: registered outputs are presented one edge after each queued vector.
  initial begin
    logic [4:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {4'b0, cout_q, sum_q}, {4'b0, e});
      end
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c;
  } vec_t;

  initial begin
    vec_t       dir[10];
    logic [4:0] m;
    logic [8:0] m8;

    dir[0] = '{4'h0, 4'h1, 4'h1, 1'b0};
    dir[1] = '{4'h1, 4'h0, 4'h1, 1'b0};
    dir[2] = '{4'h1, 4'h1, 4'h2, 1'b0};
    dir[3] = '{4'h2, 4'h1, 4'h3, 1'b0};
    dir[4] = '{4'h8, 4'h7, 4'hF, 1'b0};
    dir[5] = '{4'hF, 4'h0, 4'hF, 1'b0};
    dir[6] = '{4'h8, 4'h8, 4'h1, 1'b1};
    dir[7] = '{4'hF, 4'h1, 4'h1, 1'b1};
    dir[8] = '{4'hF, 4'hF, 4'hF, 1'b1};
    dir[9] = '{4'h7, 4'h7, 4'hE, 1'b0};

    // Two cycles of reset; combinational path is unaffected.
    drive(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, "rst0");
    drive(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, "rst1");
    @(posedge clk);
    #1;
    check("reset_sum_q", {5'b0, sum_q}, 9'h0);
    check("reset_cout_q", {8'b0, cout_q}, 9'h0);

    // Release with a wrapping vector; registered copy must not move before the edge.
    drive(4'h8, 4'h8, 1'b1, 4'h1, 1'b1, "rel_8p8");
    check("hold_before_edge", {4'b0, cout_q, sum_q}, 9'h0);

    for (int i = 0; i < 10; i++) begin
      drive(dir[i].a, dir[i].b, 1'b1, dir[i].s, dir[i].c, $sformatf("dir%0d", i));
    end

    // Mid-stream reset zeroes one edge, then the next edge captures the live inputs.
    drive(4'h3, 4'h4, 1'b1, 4'h7, 1'b0, "pre_mid");
    drive(4'hF, 4'hF, 1'b0, 4'hF, 1'b1, "mid_rst");
    drive(4'h1, 4'h1, 1'b1, 4'h2, 1'b0, "post_mid");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        m = model4(4'(a), 4'(b));
        drive(4'(a), 4'(b), 1'b1, m[3:0], m[4], $sformatf("ex_%0h_%0h", a, b));
      end
    end

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      m8 = model8(a8, b8);
      #1;
      check($sformatf("w8_%02h_%02h", a8, b8), {c8, s8}, m8);
    end

`ifdef RCA_STICKY_CARRY_EN
    drive(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, "st_rst");
    repeat (3) drive(4'h1, 4'h1, 1'b1, 4'h2, 1'b0, "st_11");
    drive(4'h1, 4'h1, 1'b1, 4'h2, 1'b0, "st_11b");
    check("sticky_clear", {8'b0, carry_sticky}, 9'h0);
    drive(4'h8, 4'h8, 1'b1, 4'h1, 1'b1, "st_88");
    drive(4'h1, 4'h1, 1'b1, 4'h2, 1'b0, "st_back");
    check("sticky_set", {8'b0, carry_sticky}, 9'h1);
    drive(4'h1, 4'h1, 1'b1, 4'h2, 1'b0, "st_hold");
    check("sticky_hold", {8'b0, carry_sticky}, 9'h1);
    // Reset and a wrapping input on the same edge: reset wins.
    drive(4'h8, 4'h8, 1'b0, 4'h1, 1'b1, "st_prio");
    drive(4'h1, 4'h1, 1'b1, 4'h2, 1'b0, "st_after");
    check("sticky_reset", {8'b0, carry_sticky}, 9'h0);
`endif

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 9'(exp_q.size()), 9'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
